// File: rtl/ct_hpcp_evtsel_bank.sv
// HPCP event-selector bank: EVT_NUM mhpmevent registers behind one indexed
// write/read port, with per-channel event IDs, count enables and LCOFI pulse.

module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic clk_en_bf_latch;
  logic clk_en_lat;

  assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

  // Transparent while the clock is low so the enable is stable across the high phase.
  always_latch begin
    if (!clk_in) clk_en_lat <= clk_en_bf_latch | pad_yy_icg_scan_en;
  end

  assign clk_out = clk_in & clk_en_lat;

endmodule

module ct_hpcp_evtsel_bank #(
  parameter int EVT_NUM   = 29,
  parameter int EVT_WIDTH = 6,
  parameter int EVT_MAX   = 42,
  parameter int IDX_W     = 5
) (
  input  logic                           forever_cpuclk,
  input  logic                           cpurst_b,
  input  logic                           cp0_hpcp_icg_en,
  input  logic                           pad_yy_icg_scan_en,
  input  logic                           hpcp_wen,
  input  logic [EVT_NUM-1:0]             hpcp_wsel,
  input  logic [63:0]                    hpcp_wdata,
  input  logic                           hpcp_ren,
  input  logic [IDX_W-1:0]               hpcp_ridx,
  input  logic [EVT_NUM-1:0]             hpcp_cnt_of,
  input  logic [1:0]                     cp0_yy_priv_mode,
  output logic [63:0]                    hpcp_rdata,
  output logic                           hpcp_rvld,
  output logic [EVT_NUM*EVT_WIDTH-1:0]   evt_id,
  output logic [EVT_NUM-1:0]             evt_cnt_en,
  output logic                           hpcp_lcofi_pulse
);

  localparam logic [EVT_WIDTH-1:0] EVT_MAX_V = EVT_WIDTH'(EVT_MAX);
  localparam logic [IDX_W:0]       EVT_NUM_V = (IDX_W + 1)'(EVT_NUM);

  logic                                 bank_clk;
  logic                                 bank_clk_en;
  logic [EVT_NUM-1:0]                   of_q;
  logic [EVT_NUM-1:0]                   minh_q;
  logic [EVT_NUM-1:0]                   sinh_q;
  logic [EVT_NUM-1:0]                   uinh_q;
  logic [EVT_NUM-1:0][EVT_WIDTH-1:0]    evt_q;
  logic [EVT_NUM-1:0]                   wr_hit;
  logic [EVT_NUM-1:0]                   of_set;
  logic                                 wr_evt_ok;
  logic [EVT_WIDTH-1:0]                 wr_evt;
  logic [63:0]                          rd_entry;
  logic                                 rd_in_range;

  assign bank_clk_en = hpcp_wen | (|hpcp_cnt_of);

  gated_clk_cell u_bank_icg (
    .clk_in             (forever_cpuclk),
    .global_en          (1'b1),
    .module_en          (cp0_hpcp_icg_en),
    .local_en           (bank_clk_en),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (bank_clk)
  );

  // WARL event field: any set reserved bit or an ID beyond EVT_MAX collapses to 0.
  assign wr_evt_ok = (hpcp_wdata[59:EVT_WIDTH] == '0) &&
                     (hpcp_wdata[EVT_WIDTH-1:0] <= EVT_MAX_V);
  assign wr_evt    = wr_evt_ok ? hpcp_wdata[EVT_WIDTH-1:0] : '0;
  assign wr_hit    = hpcp_wen ? hpcp_wsel : '0;

  // A same-cycle write wins, so its channel's overflow pulse is dropped.
  assign of_set    = hpcp_cnt_of & ~wr_hit & ~of_q;

  always_ff @(posedge bank_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      of_q   <= '0;
      minh_q <= '0;
      sinh_q <= '0;
      uinh_q <= '0;
      evt_q  <= '0;
    end else begin
      for (int i = 0; i < EVT_NUM; i++) begin
        if (wr_hit[i]) begin
          of_q[i]   <= hpcp_wdata[63];
          minh_q[i] <= hpcp_wdata[62];
          sinh_q[i] <= hpcp_wdata[61];
          uinh_q[i] <= hpcp_wdata[60];
          evt_q[i]  <= wr_evt;
        end else if (hpcp_cnt_of[i]) begin
          of_q[i]   <= 1'b1;
        end
      end
    end
  end

  assign evt_id = evt_q;

  always_comb begin
    evt_cnt_en = '0;
    for (int i = 0; i < EVT_NUM; i++) begin
      case (cp0_yy_priv_mode)
        2'b11:   evt_cnt_en[i] = (evt_q[i] != '0) & ~minh_q[i];
        2'b01:   evt_cnt_en[i] = (evt_q[i] != '0) & ~sinh_q[i];
        2'b00:   evt_cnt_en[i] = (evt_q[i] != '0) & ~uinh_q[i];
        default: evt_cnt_en[i] = 1'b0;
      endcase
    end
  end

  assign rd_in_range = {1'b0, hpcp_ridx} < EVT_NUM_V;

  always_comb begin
    rd_entry = '0;
    if (rd_in_range) begin
      rd_entry[63]            = of_q[hpcp_ridx];
      rd_entry[62]            = minh_q[hpcp_ridx];
      rd_entry[61]            = sinh_q[hpcp_ridx];
      rd_entry[60]            = uinh_q[hpcp_ridx];
      rd_entry[EVT_WIDTH-1:0] = evt_q[hpcp_ridx];
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      hpcp_rvld  <= 1'b0;
      hpcp_rdata <= '0;
    end else begin
      hpcp_rvld <= hpcp_ren;
      if (hpcp_ren) hpcp_rdata <= rd_entry;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) hpcp_lcofi_pulse <= 1'b0;
    else           hpcp_lcofi_pulse <= |of_set;
  end

endmodule
